pulse_len_encoder: RTL
======================

Name: pulse_len_encoder

Overview:
Transmit side of the team's 2-bit pulse-length line code. The block accepts 2-bit symbols over a valid/ready handshake and drives a single serial line `b`. Each symbol is sent as one high pulse whose length encodes the symbol, followed by a mandatory low gap. Shorter pulses map to larger codes: 11 is sent as 1 cycle high, 10 as 2 cycles, 01 as LONG_LEN cycles. A line receiver sitting on `b` classifies each pulse when the line falls.

Parameters:
LONG_LEN, 3, high-time in cycles for symbol 01; legal range 3..15 (any length of 3 or more decodes as 01).
GAP_CYCLES, 1, low cycles forced after every pulse; legal range 1..15 (the receiver needs at least one low cycle to emit).
CNT_W, 4, width of the internal down-counter; must hold max(LONG_LEN, GAP_CYCLES)-1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
sym  input  2  symbol to send; sampled only on handshake
sym_valid  input  1  sym is valid
sym_ready  output  1  block can accept sym this cycle
b  output  1  encoded serial line, registered
busy  output  1  1 while state != IDLE
err  output  1  one-cycle pulse: symbol 00 was accepted and dropped
sent_cnt  output  8  count of pulses transmitted, wraps 255 -> 0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, b=0, busy=0, err=0, sent_cnt=0, sym_ready=1 once rst=1.
- Reset asserted mid-pulse: `b` drops immediately, the symbol in flight is lost, and sent_cnt is cleared.
- Handshake: a transfer occurs on a rising edge with sym_valid=1 and sym_ready=1. sym_valid may be held with sym changing while sym_ready=0; only the value present at the handshake edge is used.
- sym_ready is combinational: 1 when state=IDLE, or when state=GAP and cnt=0 (last gap cycle). This allows back-to-back symbols with exactly GAP_CYCLES low cycles between pulses.
- Pulse length L: sym=11 gives L=1; sym=10 gives L=2; sym=01 gives L=LONG_LEN.
- State machine (states IDLE, PULSE, GAP):
  - IDLE or last GAP cycle, transfer with sym != 00: go to PULSE, cnt <= L-1.
  - IDLE or last GAP cycle, transfer with sym = 00: go to IDLE, err <= 1 for one cycle, no pulse.
  - Last GAP cycle, no transfer: go to IDLE.
  - PULSE, cnt != 0: cnt <= cnt-1.
  - PULSE, cnt = 0: go to GAP, cnt <= GAP_CYCLES-1, sent_cnt <= sent_cnt+1.
  - GAP, cnt != 0: cnt <= cnt-1.
- b is a flop: b = 1 exactly in cycles where state=PULSE. Latency from the handshake edge to b rising is one edge; b is high for exactly L cycles.
- err is registered, one cycle wide, and set in the cycle after the 00 handshake.
- Low time between consecutive pulses is never less than GAP_CYCLES.
- sent_cnt increments on the PULSE -> GAP edge and wraps modulo 256.
- Invalid parameters (LONG_LEN < 3, GAP_CYCLES = 0) are caught by an elaboration-time check.

Decomposition:
- Shared package pulse_code_pkg holds:
  - symbol constants SYM_NONE=2'b00, SYM_LONG=2'b01, SYM_MED=2'b10, SYM_SHORT=2'b11;
  - LEN_SHORT=1, LEN_MED=2;
  - the state enum {IDLE, PULSE, GAP}.
- The receiver uses the same symbol constants from this package.
- One natural sub-module: pulse_down_counter (load/decrement/zero flag, CNT_W wide), shared by the PULSE and GAP phases.

Test Plan:
1. Reset, then send sym=11 in one handshake -> b high for exactly 1 cycle starting one edge later, then low ≥1 cycle; sent_cnt=1; a receiver on b reports 11.
2. sym_valid held high with the sequence 11,10,01 (defaults) -> b pattern 1,0,1,1,0,1,1,1,0; sym_ready high only in IDLE and the final gap cycle; sent_cnt=3.
3. sym=00 handshake -> b stays 0, err=1 for exactly one cycle, sent_cnt unchanged, sym_ready stays 1.
4. GAP_CYCLES=3, LONG_LEN=5, back-to-back 01,01 -> 5 high, 3 low, 5 high; no gap shorter than 3.
5. rst pulled low during the 2nd high cycle of a 01 pulse -> b=0 immediately, busy=0, sent_cnt=0; the next symbol after release is sent normally.
6. 256 consecutive 11 symbols -> sent_cnt wraps to 0; sym_valid toggled randomly alongside produces no lost or duplicated pulses versus the accepted-handshake count.

Source files
------------

// File: rtl/pulse_code_pkg.sv
// ============================================================================
// pulse_code_pkg : shared symbol constants and state type for the 2-bit
//                  pulse-length line code (transmitter and receiver).
// Revision 1.0
// ============================================================================
`default_nettype none

package pulse_code_pkg;

  localparam logic [1:0] SYM_NONE  = 2'b00;
  localparam logic [1:0] SYM_LONG  = 2'b01;
  localparam logic [1:0] SYM_MED   = 2'b10;
  localparam logic [1:0] SYM_SHORT = 2'b11;

  localparam int unsigned LEN_SHORT = 1;
  localparam int unsigned LEN_MED   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // High time for a symbol; SYM_NONE has no pulse and reports zero.
  function automatic int unsigned pulse_len(input logic [1:0] s, input int unsigned long_len);
    case (s)
      SYM_SHORT: return LEN_SHORT;
      SYM_MED:   return LEN_MED;
      SYM_LONG:  return long_len;
      default:   return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_down_counter.sv
// ============================================================================
// pulse_down_counter : loadable down-counter with zero flag, shared by the
//                      pulse and gap phases of the encoder.
// Revision 1.0
// ============================================================================
`default_nettype none

module pulse_down_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_len_encoder.sv
// ============================================================================
// pulse_len_encoder : sends 2-bit symbols as one high pulse of symbol-dependent
//                     length followed by a forced low gap on serial line b.
// Revision 1.0
// ============================================================================
`default_nettype none

module pulse_len_encoder
  import pulse_code_pkg::*;
#(
  parameter int unsigned LONG_LEN   = 3,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       b,
  output logic       busy,
  output logic       err,
  output logic [7:0] sent_cnt
);

  generate
    if ((LONG_LEN < 3) || (LONG_LEN > 15) || (GAP_CYCLES < 1) || (GAP_CYCLES > 15) ||
        ((LONG_LEN - 1) >= (1 << CNT_W)) || ((GAP_CYCLES - 1) >= (1 << CNT_W))) begin : g_param_check
      $fatal(1, "pulse_len_encoder: illegal LONG_LEN/GAP_CYCLES/CNT_W combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic             b_q, b_d;
  logic             err_q, err_d;
  logic [7:0]       sent_q, sent_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             accept;
  logic [CNT_W-1:0] sym_load;

  assign sym_ready = (state_q == IDLE) || ((state_q == GAP) && cnt_zero);
  assign accept    = sym_valid && sym_ready;
  assign sym_load  = CNT_W'(pulse_len(sym, LONG_LEN) - 1);

  always_comb begin
    state_d      = state_q;
    err_d        = 1'b0;
    sent_d       = sent_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if ((state_q == GAP) && !cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          // Idle and the final gap cycle share the same acceptance rules.
          state_d = IDLE;
          if (accept) begin
            if (sym == SYM_NONE) begin
              err_d = 1'b1;
            end else begin
              state_d      = PULSE;
              cnt_load     = 1'b1;
              cnt_load_val = sym_load;
            end
          end
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_d      = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
          sent_d       = sent_q + 8'd1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    b_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      b_q     <= 1'b0;
      err_q   <= 1'b0;
      sent_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
    end
  end

  pulse_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign b        = b_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;
  assign sent_cnt = sent_q;

endmodule

`default_nettype wire
